// File: rtl/countdown_timer.sv
// Millisecond-resolution hh:mm:ss.mmm countdown timer with expiry flag.
// Optional feature: define AUTO_RELOAD_EN to reload the preset and keep running on expiry.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic [9:0] msec_preset,
    input  logic [5:0] sec_preset,
    input  logic [5:0] min_preset,
    input  logic [4:0] hour_preset,
    output logic [9:0] msec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic       running_o,
    output logic       done_o,
    output logic       expired_o
);

    localparam int unsigned DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [9:0] msec;
    } hms_t;

    state_t           state_q;
    hms_t             count_q;
    logic [DIV_W-1:0] div_q;
    logic             done_q;
`ifdef AUTO_RELOAD_EN
    hms_t             reload_q;
    logic             reload_pend_q;
`endif

    hms_t preset_d;
    hms_t count_dec_d;
    logic count_zero;
    logic dec_zero;

    function automatic hms_t clamp_preset(input logic [4:0] h, input logic [5:0] m,
                                          input logic [5:0] s, input logic [9:0] ms);
        hms_t r;
        r.hour = (h  > 5'd23)   ? 5'd23   : h;
        r.min  = (m  > 6'd59)   ? 6'd59   : m;
        r.sec  = (s  > 6'd59)   ? 6'd59   : s;
        r.msec = (ms > 10'd999) ? 10'd999 : ms;
        return r;
    endfunction

    // Borrow chain; an all-zero count stays at zero.
    function automatic hms_t dec_count(input hms_t c);
        hms_t r;
        r = c;
        if (c.msec != 10'd0) begin
            r.msec = c.msec - 10'd1;
        end else if (c.sec != 6'd0) begin
            r.msec = 10'd999;
            r.sec  = c.sec - 6'd1;
        end else if (c.min != 6'd0) begin
            r.msec = 10'd999;
            r.sec  = 6'd59;
            r.min  = c.min - 6'd1;
        end else if (c.hour != 5'd0) begin
            r.msec = 10'd999;
            r.sec  = 6'd59;
            r.min  = 6'd59;
            r.hour = c.hour - 5'd1;
        end
        return r;
    endfunction

    always_comb begin
        preset_d    = clamp_preset(hour_preset, min_preset, sec_preset, msec_preset);
        count_dec_d = dec_count(count_q);
        count_zero  = (count_q == '0);
        dec_zero    = (count_dec_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            count_q       <= '0;
            div_q         <= '0;
            done_q        <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q      <= '0;
            reload_pend_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (load_i) begin
                count_q <= preset_d;
                div_q   <= '0;
                state_q <= IDLE;
`ifdef AUTO_RELOAD_EN
                reload_q      <= preset_d;
                reload_pend_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            div_q <= '0;
                            if (count_zero) begin
                                state_q <= EXPIRED;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= RUN;
                            end
                        end
                    end
                    RUN: begin
`ifdef AUTO_RELOAD_EN
                        // Zero is held for one cycle after done_o, then the preset comes back.
                        if (reload_pend_q) begin
                            reload_pend_q <= 1'b0;
                            div_q         <= '0;
                            if (reload_q == '0) begin
                                state_q <= EXPIRED;
                            end else begin
                                count_q <= reload_q;
                            end
                        end else
`endif
                        if (!start_i && pause_i) begin
                            state_q <= PAUSE;
                        end else if (div_q == DIV_LAST) begin
                            div_q   <= '0;
                            count_q <= count_dec_d;
                            if (dec_zero) begin
                                done_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
                                reload_pend_q <= 1'b1;
`else
                                state_q <= EXPIRED;
`endif
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (start_i) begin
                            state_q <= RUN;
                        end
                    end
                    EXPIRED: begin
                        state_q <= EXPIRED;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign msec      = count_q.msec;
    assign sec       = count_q.sec;
    assign min       = count_q.min;
    assign hour      = count_q.hour;
    assign running_o = (state_q == RUN);
    assign done_o    = done_q;
    assign expired_o = (state_q == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4: vector table plus long-run sequences.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_i, load_i, start_i, pause_i;
    logic [9:0] msec_preset;
    logic [5:0] sec_preset, min_preset;
    logic [4:0] hour_preset;
    logic [9:0] msec;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       running_o, done_o, expired_o;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .start_i(start_i), .pause_i(pause_i),
        .msec_preset(msec_preset), .sec_preset(sec_preset),
        .min_preset(min_preset), .hour_preset(hour_preset),
        .msec(msec), .sec(sec), .min(min), .hour(hour),
        .running_o(running_o), .done_o(done_o), .expired_o(expired_o)
    );

    typedef struct {
        string      name;
        logic       rst, load, start, pause;
        logic [4:0] ph;
        logic [5:0] pm, ps;
        logic [9:0] pms;
        logic [4:0] eh;
        logic [5:0] em, es;
        logic [9:0] ems;
        logic       er, ed, ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic r, l, s, p,
                                input int ph, pm, ps, pms,
                                input int eh, em, es, ems,
                                input logic er, ed, ee);
        vec_t v;
        v.name = nm; v.rst = r; v.load = l; v.start = s; v.pause = p;
        v.ph = 5'(ph); v.pm = 6'(pm); v.ps = 6'(ps); v.pms = 10'(pms);
        v.eh = 5'(eh); v.em = 6'(em); v.es = 6'(es); v.ems = 10'(ems);
        v.er = er; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic drive(input logic r, l, s, p, input int h, m, sc, ms);
        rst_i = r; load_i = l; start_i = s; pause_i = p;
        hour_preset = 5'(h); min_preset = 6'(m); sec_preset = 6'(sc); msec_preset = 10'(ms);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check(input string nm, input int h, m, s, ms, input logic r, d, e);
        n_vec++;
        if ({hour, min, sec, msec, running_o, done_o, expired_o} !==
            {5'(h), 6'(m), 6'(s), 10'(ms), r, d, e}) begin
            n_bad++;
            $display("FAIL %s: got %0d:%0d:%0d.%0d run=%b done=%b exp=%b, expected %0d:%0d:%0d.%0d run=%b done=%b exp=%b",
                     nm, hour, min, sec, msec, running_o, done_o, expired_o,
                     h, m, s, ms, r, d, e);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    initial begin
        int c;
        logic found;

        rst_i = 1'b1; load_i = 1'b0; start_i = 1'b0; pause_i = 1'b0;
        hour_preset = '0; min_preset = '0; sec_preset = '0; msec_preset = '0;

        //                name          rst ld st pa   ph pm  ps  pms     eh em  es  ems   run done exp
        vecs.push_back(mk("reset",       1, 0, 0, 0,   0, 0,  0, 0,      0, 0,  0, 0,     0, 0, 0));
        vecs.push_back(mk("clamp_all",   0, 1, 0, 0,  31,63, 63, 1023,  23,59, 59, 999,   0, 0, 0));
        vecs.push_back(mk("start",       0, 0, 1, 0,   0, 0,  0, 0,     23,59, 59, 999,   1, 0, 0));
        vecs.push_back(mk("div1",        0, 0, 0, 0,   0, 0,  0, 0,     23,59, 59, 999,   1, 0, 0));
        vecs.push_back(mk("div2",        0, 0, 0, 0,   0, 0,  0, 0,     23,59, 59, 999,   1, 0, 0));
        vecs.push_back(mk("div3",        0, 0, 0, 0,   0, 0,  0, 0,     23,59, 59, 999,   1, 0, 0));
        vecs.push_back(mk("first_tick",  0, 0, 0, 0,   0, 0,  0, 0,     23,59, 59, 998,   1, 0, 0));
        vecs.push_back(mk("load_start",  0, 1, 1, 0,   0, 0,  2, 0,      0, 0,  2, 0,     0, 0, 0));
        vecs.push_back(mk("clamp_mix",   0, 1, 0, 0,  23,60,  0, 999,   23,59,  0, 999,   0, 0, 0));
        vecs.push_back(mk("load_zero",   0, 1, 0, 0,   0, 0,  0, 0,      0, 0,  0, 0,     0, 0, 0));
        vecs.push_back(mk("zero_start",  0, 0, 1, 0,   0, 0,  0, 0,      0, 0,  0, 0,     0, 1, 1));
        vecs.push_back(mk("zero_after",  0, 0, 0, 0,   0, 0,  0, 0,      0, 0,  0, 0,     0, 0, 1));
        vecs.push_back(mk("exp_ignore",  0, 0, 1, 1,   0, 0,  0, 0,      0, 0,  0, 0,     0, 0, 1));
        vecs.push_back(mk("load_5",      0, 1, 0, 0,   0, 0,  0, 5,      0, 0,  0, 5,     0, 0, 0));
        vecs.push_back(mk("idle_pause",  0, 0, 0, 1,   0, 0,  0, 0,      0, 0,  0, 5,     0, 0, 0));
        vecs.push_back(mk("start_5",     0, 0, 1, 0,   0, 0,  0, 0,      0, 0,  0, 5,     1, 0, 0));
        vecs.push_back(mk("r1",          0, 0, 0, 0,   0, 0,  0, 0,      0, 0,  0, 5,     1, 0, 0));
        vecs.push_back(mk("r2",          0, 0, 0, 0,   0, 0,  0, 0,      0, 0,  0, 5,     1, 0, 0));
        vecs.push_back(mk("r3",          0, 0, 0, 0,   0, 0,  0, 0,      0, 0,  0, 5,     1, 0, 0));
        vecs.push_back(mk("pause_hold",  0, 0, 0, 1,   0, 0,  0, 0,      0, 0,  0, 5,     0, 0, 0));
        vecs.push_back(mk("resume",      0, 0, 1, 0,   0, 0,  0, 0,      0, 0,  0, 5,     1, 0, 0));
        vecs.push_back(mk("held_div",    0, 0, 0, 0,   0, 0,  0, 0,      0, 0,  0, 4,     1, 0, 0));
        vecs.push_back(mk("load_1h",     0, 1, 0, 0,   1, 0,  0, 0,      1, 0,  0, 0,     0, 0, 0));
        vecs.push_back(mk("start_1h",    0, 0, 1, 0,   0, 0,  0, 0,      1, 0,  0, 0,     1, 0, 0));
        vecs.push_back(mk("h1",          0, 0, 0, 0,   0, 0,  0, 0,      1, 0,  0, 0,     1, 0, 0));
        vecs.push_back(mk("h2",          0, 0, 0, 0,   0, 0,  0, 0,      1, 0,  0, 0,     1, 0, 0));
        vecs.push_back(mk("h3",          0, 0, 0, 0,   0, 0,  0, 0,      1, 0,  0, 0,     1, 0, 0));
        vecs.push_back(mk("hour_borrow", 0, 0, 0, 0,   0, 0,  0, 0,      0,59, 59, 999,   1, 0, 0));
        vecs.push_back(mk("rst_run",     1, 0, 0, 0,   0, 0,  0, 0,      0, 0,  0, 0,     0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].start, vecs[i].pause,
                  vecs[i].ph, vecs[i].pm, vecs[i].ps, vecs[i].pms);
            check(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].ems,
                  vecs[i].er, vecs[i].ed, vecs[i].ee);
        end

        // Full run from 1.002 down to expiry.
        drive(0, 1, 0, 0, 0, 0, 1, 2);
        check("t1_load", 0, 0, 1, 2, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        check("t1_start", 0, 0, 1, 2, 1, 0, 0);
        for (int k = 0; k < 12; k++) idle_step();
        check("t1_borrow", 0, 0, 0, 999, 1, 0, 0);
        c = 12;
        found = 1'b0;
        while (c < 4100 && !found) begin
            idle_step();
            c++;
            if (done_o) found = 1'b1;
        end
        check_int("t1_done_cycle", c, 4008);
        check("t1_done", 0, 0, 0, 0, 0, 1, 1);
        idle_step();
        check("t1_after", 0, 0, 0, 0, 0, 0, 1);

        // Pause after 5 ticks, hold 20 cycles, resume; done 5 ticks later.
        drive(0, 1, 0, 0, 0, 0, 0, 10);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) idle_step();
        check("t3_5ticks", 0, 0, 0, 5, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) idle_step();
        check("t3_frozen", 0, 0, 0, 5, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        c = 0;
        found = 1'b0;
        while (c < 100 && !found) begin
            idle_step();
            c++;
            if (done_o) found = 1'b1;
        end
        check_int("t3_done_cycle", c, 20);
        check("t3_done", 0, 0, 0, 0, 0, 1, 1);

`ifdef AUTO_RELOAD_EN
        drive(0, 1, 0, 0, 0, 0, 0, 3);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) idle_step();
        check("ar_done1", 0, 0, 0, 0, 1, 1, 0);
        idle_step();
        check("ar_reload", 0, 0, 0, 3, 1, 0, 0);
        for (int k = 0; k < 12; k++) idle_step();
        check("ar_done2", 0, 0, 0, 0, 1, 1, 0);
        for (int k = 0; k < 6; k++) idle_step();
        check("ar_mid", 0, 0, 0, 2, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        check("ar_rst", 0, 0, 0, 0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
